// File: rtl/conv_accumulator_pkg.sv
// Definitions shared by the convolution datapath stages: the multiplier,
// the accumulator and pooling.
package conv_accumulator_pkg;

    localparam int CNN_PROD_W = 16;
    localparam int BIAS_W     = 16;
    localparam int Q_W        = 8;
    localparam int Q_MAX      = 127;
    localparam int Q_MIN      = -128;

    function automatic int clog2(input int value);
        int result = 0;
        int remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_accumulator_requant_sat.sv
// Requantises a signed accumulator value to an 8-bit activation:
// round-half-up, arithmetic shift, optional ReLU, then saturate.
module requant_sat
    import conv_accumulator_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 5,
    parameter int RELU  = 1
) (
    input  logic [ACC_W-1:0] value,
    output logic [Q_W-1:0]   q
);

    // One guard bit so the rounding add cannot wrap at the top of the range.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HI = EXT_W'(Q_MAX);
    localparam logic signed [EXT_W-1:0] LO = EXT_W'(Q_MIN);

    logic signed [EXT_W-1:0] wide;
    logic signed [EXT_W-1:0] shifted;
    logic signed [EXT_W-1:0] clipped;

    assign wide = {value[ACC_W-1], value};

    if (SHIFT > 0) begin : g_round
        localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
        assign shifted = (wide + HALF) >>> SHIFT;
    end else begin : g_pass
        assign shifted = wide;
    end

    always_comb begin
        clipped = shifted;
        if (RELU != 0 && shifted[EXT_W-1]) begin
            clipped = '0;
        end
        q = clipped[Q_W-1:0];
        if (clipped > HI) begin
            q = Q_W'(Q_MAX);
        end else if (clipped < LO) begin
            q = Q_W'(Q_MIN);
        end
    end

endmodule

// File: rtl/conv_accumulator.sv
// Accumulates KERNEL_N signed products onto a per-window bias and holds the
// requantised window sum in a valid/ready output register.
module conv_accumulator
    import conv_accumulator_pkg::*;
#(
    parameter int PROD_W   = CNN_PROD_W,
    parameter int ACC_W    = 24,
    parameter int KERNEL_N = 9,
    parameter int SHIFT    = 5,
    parameter int RELU     = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PROD_W-1:0] P_IN,
    input  logic              P_VALID,
    output logic              IN_READY,
    input  logic [BIAS_W-1:0] BIAS,
    input  logic              CLEAR,
    output logic [ACC_W-1:0]  ACC_OUT,
    output logic [Q_W-1:0]    Q_OUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam int CNT_W = (KERNEL_N > 1) ? clog2(KERNEL_N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_N - 1);

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic [Q_W-1:0]          q_next;
    logic                    is_last;
    logic                    accept;

    assign p_ext    = {{(ACC_W-PROD_W){P_IN[PROD_W-1]}}, P_IN};
    assign bias_ext = {{(ACC_W-BIAS_W){BIAS[BIAS_W-1]}}, BIAS};
    assign is_last  = (cnt == LAST);
    // Only the final term can stall, and only while the held result is unconsumed.
    assign IN_READY = !(is_last && OUT_VALID && !OUT_READY);
    assign accept   = P_VALID && IN_READY && !CLEAR;
    // A window's first term starts from the bias; with KERNEL_N==1 cnt stays 0.
    assign sum      = ((cnt == '0) ? bias_ext : acc) + p_ext;

    requant_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .value (sum),
        .q     (q_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            acc       <= '0;
            ACC_OUT   <= '0;
            Q_OUT     <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            if (CLEAR) begin
                cnt <= '0;
                acc <= '0;
            end else if (accept) begin
                acc <= sum;
                cnt <= is_last ? '0 : cnt + CNT_W'(1);
            end

            if (accept && is_last) begin
                ACC_OUT   <= sum;
                Q_OUT     <= q_next;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: three KERNEL_N=3 instances (differing SHIFT/RELU)
// share one stimulus bus, a KERNEL_N=9 instance has its own.
module tb_conv_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] p_in3 = '0, bias3 = '0, p_in9 = '0, bias9 = '0;
    logic p_valid3 = 1'b0, clear3 = 1'b0, out_ready3 = 1'b0;
    logic p_valid9 = 1'b0, clear9 = 1'b0, out_ready9 = 1'b0;

    logic        in_ready_a, in_ready_b, in_ready_c, in_ready_d;
    logic [23:0] acc_a, acc_b, acc_c, acc_d;
    logic [7:0]  q_a, q_b, q_c, q_d;
    logic        valid_a, valid_b, valid_c, valid_d;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state per group: 0 = KERNEL_N 3, 1 = KERNEL_N 9
    int     wcnt [2];
    longint wsum [2];
    bit     ev   [2];
    longint esum [2];

    conv_accumulator #(.PROD_W(16), .ACC_W(24), .KERNEL_N(3), .SHIFT(5), .RELU(0)) u_a (
        .CLK(clk), .RST(rst), .P_IN(p_in3), .P_VALID(p_valid3), .IN_READY(in_ready_a),
        .BIAS(bias3), .CLEAR(clear3), .ACC_OUT(acc_a), .Q_OUT(q_a), .OUT_VALID(valid_a),
        .OUT_READY(out_ready3));
    conv_accumulator #(.PROD_W(16), .ACC_W(24), .KERNEL_N(3), .SHIFT(5), .RELU(1)) u_b (
        .CLK(clk), .RST(rst), .P_IN(p_in3), .P_VALID(p_valid3), .IN_READY(in_ready_b),
        .BIAS(bias3), .CLEAR(clear3), .ACC_OUT(acc_b), .Q_OUT(q_b), .OUT_VALID(valid_b),
        .OUT_READY(out_ready3));
    conv_accumulator #(.PROD_W(16), .ACC_W(24), .KERNEL_N(3), .SHIFT(1), .RELU(0)) u_c (
        .CLK(clk), .RST(rst), .P_IN(p_in3), .P_VALID(p_valid3), .IN_READY(in_ready_c),
        .BIAS(bias3), .CLEAR(clear3), .ACC_OUT(acc_c), .Q_OUT(q_c), .OUT_VALID(valid_c),
        .OUT_READY(out_ready3));
    conv_accumulator #(.PROD_W(16), .ACC_W(24), .KERNEL_N(9), .SHIFT(0), .RELU(0)) u_d (
        .CLK(clk), .RST(rst), .P_IN(p_in9), .P_VALID(p_valid9), .IN_READY(in_ready_d),
        .BIAS(bias9), .CLEAR(clear9), .ACC_OUT(acc_d), .Q_OUT(q_d), .OUT_VALID(valid_d),
        .OUT_READY(out_ready9));

    function automatic int kn(int g);
        return (g == 0) ? 3 : 9;
    endfunction

    // round half up by floor division, then ReLU and clamp
    function automatic int requant_ref(longint s, int sh, bit rl);
        longint d, t, r;
        if (sh > 0) begin
            d = longint'(1) << sh;
            t = s + d / 2;
            r = t / d;
            if (t < 0 && (t % d) != 0) r = r - 1;
        end else begin
            r = s;
        end
        if (rl && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic bit exp_ready(int g, bit ordy);
        return !(wcnt[g] == kn(g) - 1 && ev[g] && !ordy);
    endfunction

    function automatic logic [32:0] exp_vec(int g, int sh, bit rl);
        logic [23:0] a;
        logic [7:0]  q;
        a = esum[g][23:0];
        q = 8'(requant_ref(esum[g], sh, rl));
        return {ev[g], a, q};
    endfunction

    task automatic model_step(int g, bit pv, logic [15:0] p, logic [15:0] b, bit clr, bit ordy);
        bit take, load;
        take = pv && exp_ready(g, ordy) && !clr;
        load = take && (wcnt[g] == kn(g) - 1);
        if (rst) begin
            wcnt[g] = 0; wsum[g] = 0; ev[g] = 0; esum[g] = 0;
        end else begin
            if (clr) begin
                wcnt[g] = 0;
                wsum[g] = 0;
            end else if (take) begin
                if (wcnt[g] == 0) wsum[g] = longint'($signed(b));
                wsum[g] += longint'($signed(p));
                wcnt[g] = (wcnt[g] + 1) % kn(g);
            end
            if (load) begin
                esum[g] = wsum[g];
                ev[g]   = 1'b1;
            end else if (ordy) begin
                ev[g] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step(0, p_valid3, p_in3, bias3, clear3, out_ready3);
        model_step(1, p_valid9, p_in9, bias9, clear9, out_ready9);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid3 = 1'b0; clear3 = 1'b0;
        p_valid9 = 1'b0; clear9 = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic feed3(logic [15:0] v);
        p_in3 = v;
        p_valid3 = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        out_ready3 = 1'b0; out_ready9 = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if ({valid_a, acc_a, q_a} !== 33'd0) begin n_bad++; $display("FAIL reset_a: got %h want 0", {valid_a, acc_a, q_a}); end
        n_cmp++; if ({valid_b, acc_b, q_b} !== 33'd0) begin n_bad++; $display("FAIL reset_b: got %h want 0", {valid_b, acc_b, q_b}); end
        n_cmp++; if ({valid_c, acc_c, q_c} !== 33'd0) begin n_bad++; $display("FAIL reset_c: got %h want 0", {valid_c, acc_c, q_c}); end
        n_cmp++; if ({valid_d, acc_d, q_d} !== 33'd0) begin n_bad++; $display("FAIL reset_d: got %h want 0", {valid_d, acc_d, q_d}); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({in_ready_a, in_ready_b, in_ready_c, in_ready_d} !== 4'b1111) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1111", {in_ready_a, in_ready_b, in_ready_c, in_ready_d});
        end
    endtask

    task automatic test_basic_window();
        int prods [3] = '{-1200, -800, -400};
        do_reset();
        bias3 = 16'd0;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_in3 = 16'(prods[i]);
            p_valid3 = 1'b1;
            #1;
            n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready%0d: got %b want 1", i, in_ready_a); end
            tick();
            if (i < 2) begin
                n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid%0d: got %b want 0", i, valid_a); end
            end
        end
        idle();
        n_cmp++; if (acc_a !== 24'(-2400)) begin n_bad++; $display("FAIL basic_acc: got %0d want -2400", $signed(acc_a)); end
        n_cmp++; if (q_a !== 8'hB5) begin n_bad++; $display("FAIL basic_q: got %h want b5", q_a); end
        n_cmp++; if (q_b !== 8'h00) begin n_bad++; $display("FAIL basic_q_relu: got %h want 00", q_b); end
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", valid_a); end
        n_cmp++; if ({valid_c, acc_c, q_c} !== exp_vec(0, 1, 0)) begin
            n_bad++; $display("FAIL basic_shift1: got %h want %h", {valid_c, acc_c, q_c}, exp_vec(0, 1, 0));
        end
        tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL basic_valid_pulse: got %b want 0", valid_a); end
    endtask

    task automatic test_bias_sat();
        do_reset();
        out_ready3 = 1'b1;
        bias3 = 16'd100;
        feed3(16'd10); feed3(16'd20); feed3(16'd30);
        idle();
        n_cmp++; if (acc_c !== 24'd160) begin n_bad++; $display("FAIL bias_acc: got %0d want 160", $signed(acc_c)); end
        n_cmp++; if (q_c !== 8'd80) begin n_bad++; $display("FAIL bias_q: got %0d want 80", $signed(q_c)); end
        n_cmp++; if ({valid_a, acc_a, q_a} !== exp_vec(0, 5, 0)) begin
            n_bad++; $display("FAIL bias_shift5: got %h want %h", {valid_a, acc_a, q_a}, exp_vec(0, 5, 0));
        end
        // bias only counts when sampled with a window's first term
        bias3 = 16'd0;
        feed3(16'd16384);
        bias3 = 16'd999;
        feed3(16'd16384); feed3(16'd16384);
        idle();
        n_cmp++; if (acc_a !== 24'd49152) begin n_bad++; $display("FAIL sat_acc: got %0d want 49152", $signed(acc_a)); end
        n_cmp++; if (q_a !== 8'd127) begin n_bad++; $display("FAIL sat_q: got %0d want 127", $signed(q_a)); end
        n_cmp++; if (q_b !== 8'd127) begin n_bad++; $display("FAIL sat_q_relu: got %0d want 127", $signed(q_b)); end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [6];
        longint s1, s2;
        do_reset();
        bias3 = 16'($urandom);
        for (int i = 0; i < 6; i++) vals[i] = 16'($urandom);
        s1 = longint'($signed(bias3)) + longint'($signed(vals[0])) + longint'($signed(vals[1])) + longint'($signed(vals[2]));
        s2 = longint'($signed(bias3)) + longint'($signed(vals[3])) + longint'($signed(vals[4])) + longint'($signed(vals[5]));
        out_ready3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p_in3 = vals[i];
            p_valid3 = 1'b1;
            #1;
            n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL bp_ready_term%0d: got %b want 1", i + 1, in_ready_a); end
            tick();
            if (i >= 2) begin
                n_cmp++; if ({valid_a, acc_a} !== {1'b1, s1[23:0]}) begin
                    n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i + 1, {valid_a, acc_a}, {1'b1, s1[23:0]});
                end
            end
        end
        p_in3 = vals[5];
        repeat (2) begin
            #1;
            n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got %b want 0", in_ready_a); end
            tick();
            n_cmp++; if ({valid_a, acc_a} !== {1'b1, s1[23:0]}) begin
                n_bad++; $display("FAIL bp_stall_hold: got %h want %h", {valid_a, acc_a}, {1'b1, s1[23:0]});
            end
        end
        out_ready3 = 1'b1;
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", in_ready_a); end
        tick();
        idle();
        out_ready3 = 1'b0;
        n_cmp++; if ({valid_a, acc_a, q_a} !== {1'b1, s2[23:0], 8'(requant_ref(s2, 5, 0))}) begin
            n_bad++; $display("FAIL bp_second: got %h want %h", {valid_a, acc_a, q_a}, {1'b1, s2[23:0], 8'(requant_ref(s2, 5, 0))});
        end
        tick();
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL bp_second_held: got %b want 1", valid_a); end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL bp_consumed: got %b want 0", valid_a); end
    endtask

    task automatic test_gapped();
        int taken = 0;
        int cycles = 0;
        bit early = 1'b0;
        do_reset();
        bias9 = 16'd0;
        out_ready9 = 1'b1;
        while (taken < 9 && cycles < 40) begin
            p_valid9 = (cycles % 2 == 0);
            p_in9 = 16'(taken + 1);
            tick();
            cycles++;
            if (p_valid9) taken++;
            if (taken < 9 && valid_d) early = 1'b1;
        end
        idle();
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL gap_early_valid: got %b want 0", early); end
        n_cmp++; if (acc_d !== 24'd45) begin n_bad++; $display("FAIL gap_acc: got %0d want 45", $signed(acc_d)); end
        n_cmp++; if (q_d !== 8'd45) begin n_bad++; $display("FAIL gap_q: got %0d want 45", $signed(q_d)); end
        n_cmp++; if (valid_d !== 1'b1) begin n_bad++; $display("FAIL gap_valid: got %b want 1", valid_d); end
    endtask

    task automatic test_abort();
        do_reset();
        bias3 = 16'd0;
        out_ready3 = 1'b1;
        feed3(16'd500); feed3(16'd500);
        p_in3 = 16'd999; p_valid3 = 1'b1; clear3 = 1'b1;
        tick();
        clear3 = 1'b0;
        feed3(16'd1); feed3(16'd2); feed3(16'd3);
        idle();
        n_cmp++; if ({valid_a, acc_a} !== {1'b1, 24'd6}) begin n_bad++; $display("FAIL clear_acc: got %h want 1000006", {valid_a, acc_a}); end
        n_cmp++; if (q_c !== 8'd3) begin n_bad++; $display("FAIL clear_q: got %0d want 3", q_c); end

        do_reset();
        out_ready3 = 1'b0;
        feed3(16'd7); feed3(16'd8); feed3(16'd9);
        feed3(16'd500); feed3(16'd500);
        idle();
        clear3 = 1'b1;
        tick();
        clear3 = 1'b0;
        n_cmp++; if ({valid_a, acc_a} !== {1'b1, 24'd24}) begin n_bad++; $display("FAIL clear_keeps_result: got %h want 1000018", {valid_a, acc_a}); end
        feed3(16'd500); feed3(16'd500);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({valid_a, acc_a, q_a} !== 33'd0) begin n_bad++; $display("FAIL rst_outputs_a: got %h want 0", {valid_a, acc_a, q_a}); end
        n_cmp++; if ({valid_c, acc_c, q_c} !== 33'd0) begin n_bad++; $display("FAIL rst_outputs_c: got %h want 0", {valid_c, acc_c, q_c}); end
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready_a); end
        feed3(16'd1); feed3(16'd2);
        n_cmp++; if ({valid_a, acc_a} !== 25'd0) begin n_bad++; $display("FAIL rst_partial: got %h want 0", {valid_a, acc_a}); end
        out_ready3 = 1'b1;
        feed3(16'd3);
        idle();
        n_cmp++; if ({valid_a, acc_a} !== {1'b1, 24'd6}) begin n_bad++; $display("FAIL rst_new_window: got %h want 1000006", {valid_a, acc_a}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready3 = 1'b1; out_ready9 = 1'b1;
        p_valid3 = 1'b1;   p_valid9 = 1'b1;
        for (int i = 0; i < 36; i++) begin
            p_in3 = 16'($urandom); p_in9 = 16'($urandom);
            bias3 = 16'($urandom); bias9 = 16'($urandom);
            #1;
            n_cmp++; if ({in_ready_a, in_ready_d} !== 2'b11) begin n_bad++; $display("FAIL b2b_stall%0d: got %b want 11", i, {in_ready_a, in_ready_d}); end
            tick();
            n_cmp++; if (valid_a !== 1'(i % 3 == 2)) begin n_bad++; $display("FAIL b2b_valid3_%0d: got %b want %b", i, valid_a, (i % 3 == 2)); end
            n_cmp++; if (valid_d !== 1'(i % 9 == 8)) begin n_bad++; $display("FAIL b2b_valid9_%0d: got %b want %b", i, valid_d, (i % 9 == 8)); end
            n_cmp++; if ({valid_a, acc_a, q_a} !== exp_vec(0, 5, 0)) begin n_bad++; $display("FAIL b2b_a%0d: got %h want %h", i, {valid_a, acc_a, q_a}, exp_vec(0, 5, 0)); end
            n_cmp++; if ({valid_b, acc_b, q_b} !== exp_vec(0, 5, 1)) begin n_bad++; $display("FAIL b2b_b%0d: got %h want %h", i, {valid_b, acc_b, q_b}, exp_vec(0, 5, 1)); end
            n_cmp++; if ({valid_c, acc_c, q_c} !== exp_vec(0, 1, 0)) begin n_bad++; $display("FAIL b2b_c%0d: got %h want %h", i, {valid_c, acc_c, q_c}, exp_vec(0, 1, 0)); end
            n_cmp++; if ({valid_d, acc_d, q_d} !== exp_vec(1, 0, 0)) begin n_bad++; $display("FAIL b2b_d%0d: got %h want %h", i, {valid_d, acc_d, q_d}, exp_vec(1, 0, 0)); end
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            p_valid3   = ($urandom_range(0, 3) != 0);
            p_valid9   = ($urandom_range(0, 3) != 0);
            clear3     = ($urandom_range(0, 19) == 0);
            clear9     = ($urandom_range(0, 19) == 0);
            out_ready3 = ($urandom_range(0, 2) != 0);
            out_ready9 = ($urandom_range(0, 2) != 0);
            p_in3 = 16'($urandom); p_in9 = 16'($urandom);
            bias3 = 16'($urandom); bias9 = 16'($urandom);
            #1;
            if (!rst) begin
                n_cmp++; if ({in_ready_a, in_ready_b, in_ready_c} !== {3{exp_ready(0, out_ready3)}}) begin
                    n_bad++; $display("FAIL rnd_ready3_%0d: got %b want %b", i, {in_ready_a, in_ready_b, in_ready_c}, {3{exp_ready(0, out_ready3)}});
                end
                n_cmp++; if (in_ready_d !== exp_ready(1, out_ready9)) begin
                    n_bad++; $display("FAIL rnd_ready9_%0d: got %b want %b", i, in_ready_d, exp_ready(1, out_ready9));
                end
            end
            tick();
            n_cmp++; if ({valid_a, acc_a, q_a} !== exp_vec(0, 5, 0)) begin n_bad++; $display("FAIL rnd_a%0d: got %h want %h", i, {valid_a, acc_a, q_a}, exp_vec(0, 5, 0)); end
            n_cmp++; if ({valid_b, acc_b, q_b} !== exp_vec(0, 5, 1)) begin n_bad++; $display("FAIL rnd_b%0d: got %h want %h", i, {valid_b, acc_b, q_b}, exp_vec(0, 5, 1)); end
            n_cmp++; if ({valid_c, acc_c, q_c} !== exp_vec(0, 1, 0)) begin n_bad++; $display("FAIL rnd_c%0d: got %h want %h", i, {valid_c, acc_c, q_c}, exp_vec(0, 1, 0)); end
            n_cmp++; if ({valid_d, acc_d, q_d} !== exp_vec(1, 0, 0)) begin n_bad++; $display("FAIL rnd_d%0d: got %h want %h", i, {valid_d, acc_d, q_d}, exp_vec(1, 0, 0)); end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_bias_sat();
        test_backpressure();
        test_gapped();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
